// File: rtl/cd_config_mc.sv
// cd_config_mc: per-channel clock-divider limit registers written over a config bus.
// New limits are applied only at the addressed divider's period boundary, so no clock glitches.
// Latency: a commit at edge M updates lim at M; upd is a registered pulse for the cycle after M.
// Backpressure: c_ready drops only when the addressed channel still holds an uncommitted write.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   c_addr/c_data    channel select (k -> channel k-1, 0 and >NUM_CH unmapped) / new limit
//   c_valid/c_ready  write handshake; c_ready is combinational from c_addr and channel state
//   ch_tick          per-channel period-end pulse from the divider bank
//   lim              packed active limits, channel i at [i*WIDTH_LIMIT +: WIDTH_LIMIT]
//   upd              one-cycle pulse after a channel's limit is (re)loaded
//   ch_busy          channel holds an uncommitted write
//
// Optional build macro CD_CONFIG_STATUS_EN adds err_sticky / to_sticky status outputs;
// with it, a write to address 0 clears the sticky bits selected by c_data.

module cd_config_mc #(
    parameter int                              NUM_CH            = 4,
    parameter int                              WIDTH_CONFIG_ADDR = 4,
    parameter int                              WIDTH_LIMIT       = 16,
    parameter logic [NUM_CH*WIDTH_LIMIT-1:0]   RESET_LIMIT       = {NUM_CH{16'd2604}},
    parameter int                              TIMEOUT           = 1024,
    parameter int                              WIDTH_TO          = 11
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [WIDTH_CONFIG_ADDR-1:0]    c_addr,
    input  logic [WIDTH_LIMIT-1:0]          c_data,
    input  logic                            c_valid,
    output logic                            c_ready,
    input  logic [NUM_CH-1:0]               ch_tick,
    output logic [NUM_CH*WIDTH_LIMIT-1:0]   lim,
    output logic [NUM_CH-1:0]               upd,
    output logic [NUM_CH-1:0]               ch_busy
`ifdef CD_CONFIG_STATUS_EN
    ,
    output logic [NUM_CH-1:0]               err_sticky,
    output logic [NUM_CH-1:0]               to_sticky
`endif
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } st_e;

    // Last counter value before a forced commit; unused when TIMEOUT is 0.
    localparam logic [WIDTH_TO-1:0] TO_LAST = WIDTH_TO'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [WIDTH_TO-1:0] TO_MAX  = '1;

    st_e                    state_q [NUM_CH];
    st_e                    state_d [NUM_CH];
    logic [WIDTH_LIMIT-1:0] pend_q  [NUM_CH];
    logic [WIDTH_LIMIT-1:0] pend_d  [NUM_CH];
    logic [WIDTH_LIMIT-1:0] lim_q   [NUM_CH];
    logic [WIDTH_LIMIT-1:0] lim_d   [NUM_CH];
    logic [WIDTH_TO-1:0]    to_q    [NUM_CH];
    logic [WIDTH_TO-1:0]    to_d    [NUM_CH];
    logic [NUM_CH-1:0]      upd_q;
    logic [NUM_CH-1:0]      upd_d;

    logic [NUM_CH-1:0]      sel;      // one-hot channel decode of c_addr
    logic [NUM_CH-1:0]      busy;
    logic [NUM_CH-1:0]      acc;      // write accepted into channel
    logic [NUM_CH-1:0]      to_hit;   // timeout expires this cycle
    logic [NUM_CH-1:0]      commit;
    logic [WIDTH_LIMIT-1:0] clamp_data;

    // ------------------------------------------------------------------
    // Address decode and handshake
    // ------------------------------------------------------------------
    always_comb begin
        sel  = '0;
        busy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i]  = (c_addr == WIDTH_CONFIG_ADDR'(i + 1));
            busy[i] = (state_q[i] == ST_PEND);
        end
    end

    // Unmapped addresses always handshake so the bus never stalls on a bad address.
    assign c_ready    = ~|(sel & busy);
    assign acc        = {NUM_CH{c_valid}} & sel & ~busy;
    // A zero limit would stall the divider, so it is stored as 1.
    assign clamp_data = (c_data == '0) ? WIDTH_LIMIT'(1) : c_data;

    always_comb begin
        to_hit = '0;
        commit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            to_hit[i] = (TIMEOUT != 0) && busy[i] && (to_q[i] == TO_LAST);
            // Ticks only count in PENDING; a tick coinciding with the accept is ignored.
            commit[i] = busy[i] && (ch_tick[i] || to_hit[i]);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= ST_IDLE;
        end else begin
            for (int i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                ST_IDLE: if (acc[i])    state_d[i] = ST_PEND;
                ST_PEND: if (commit[i]) state_d[i] = ST_IDLE;
                default:                state_d[i] = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ch_busy = '0;
        lim     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_busy[i]                         = (state_q[i] == ST_PEND);
            lim[i*WIDTH_LIMIT +: WIDTH_LIMIT]  = lim_q[i];
        end
    end

    assign upd = upd_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pend_d[i] = pend_q[i];
            lim_d[i]  = lim_q[i];
            to_d[i]   = to_q[i];
            if (acc[i]) begin
                pend_d[i] = clamp_data;
                to_d[i]   = '0;
            end else if (busy[i] && (to_q[i] != TO_MAX)) begin
                to_d[i]   = to_q[i] + WIDTH_TO'(1);
            end
            if (commit[i]) begin
                lim_d[i]  = pend_q[i];
            end
        end
        // Reloading an identical value still restarts the divider.
        upd_d = commit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pend_q[i] <= '0;
                lim_q[i]  <= RESET_LIMIT[i*WIDTH_LIMIT +: WIDTH_LIMIT];
                to_q[i]   <= '0;
            end
            upd_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                pend_q[i] <= pend_d[i];
                lim_q[i]  <= lim_d[i];
                to_q[i]   <= to_d[i];
            end
            upd_q <= upd_d;
        end
    end

`ifdef CD_CONFIG_STATUS_EN
    // ------------------------------------------------------------------
    // Sticky status: a set in the same cycle as a clear wins.
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] err_q, err_d, tos_q, tos_d;
    logic [NUM_CH-1:0] clr;

    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            clr[i] = c_valid && (c_addr == '0) && c_data[i];
        end
        err_d = (err_q & ~clr) | ({NUM_CH{c_valid}} & sel & busy);
        // Only a commit that the tick did not cause counts as forced.
        tos_d = (tos_q & ~clr) | (to_hit & ~ch_tick);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
            tos_q <= '0;
        end else begin
            err_q <= err_d;
            tos_q <= tos_d;
        end
    end

    assign err_sticky = err_q;
    assign to_sticky  = tos_q;
`endif

endmodule

// File: tb/tb_cd_config_mc.sv
// Directed bench for cd_config_mc: expected limit updates are queued when stimulus
// is driven and popped when the DUT raises upd.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_cd_config_mc;

    localparam int NUM_CH = 4;
    localparam int WA     = 4;
    localparam int WL     = 16;

    logic                 clk;
    logic                 rst_n;
    logic [WA-1:0]        c_addr;
    logic [WL-1:0]        c_data;
    logic                 c_valid;
    logic                 c_ready;
    logic [NUM_CH-1:0]    ch_tick;
    logic [NUM_CH*WL-1:0] lim;
    logic [NUM_CH-1:0]    upd;
    logic [NUM_CH-1:0]    ch_busy;
`ifdef CD_CONFIG_STATUS_EN
    logic [NUM_CH-1:0]    err_sticky;
    logic [NUM_CH-1:0]    to_sticky;
`endif

    cd_config_mc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .c_addr     (c_addr),
        .c_data     (c_data),
        .c_valid    (c_valid),
        .c_ready    (c_ready),
        .ch_tick    (ch_tick),
        .lim        (lim),
        .upd        (upd),
        .ch_busy    (ch_busy)
`ifdef CD_CONFIG_STATUS_EN
        ,
        .err_sticky (err_sticky),
        .to_sticky  (to_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lim_of(input int ch);
        return lim[ch*WL +: WL];
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait (bounded) for an upd pulse, check it against the scoreboard head,
    // then check that the pulse lasts exactly one cycle.
    task automatic expect_upd(input int budget, output int n);
        exp_t e;
        n = 0;
        while (upd == '0 && n < budget) begin
            step();
            n++;
        end
        chk("upd_seen", {31'd0, (upd != '0)}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("upd_chan", {28'd0, upd}, 32'(1 << e.ch));
            chk("lim_commit", {16'd0, lim_of(e.ch)}, {16'd0, e.val});
        end
        step();
        chk("upd_one_cycle", {28'd0, upd}, 32'd0);
    endtask

    task automatic write(input logic [WA-1:0] a, input logic [WL-1:0] d);
        c_addr  = a;
        c_data  = d;
        c_valid = 1'b1;
        step();
        c_valid = 1'b0;
    endtask

    initial begin
        int          n;
        logic [3:0]  upd_or;

        rst_n   = 1'b0;
        c_addr  = '0;
        c_data  = '0;
        c_valid = 1'b0;
        ch_tick = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        for (int i = 0; i < NUM_CH; i++) chk("rst_lim", {16'd0, lim_of(i)}, 32'd2604);
        chk("rst_busy", {28'd0, ch_busy}, 32'd0);
        chk("rst_upd", {28'd0, upd}, 32'd0);
        for (int a = 0; a < 16; a++) begin
            c_addr = 4'(a);
            #1;
            chk("rst_ready", {31'd0, c_ready}, 32'd1);
        end

        // Write channel 1, hold pending, then tick
        c_addr = 4'd2;
        c_data = 16'd1302;
        c_valid = 1'b1;
        #1;
        chk("rdy_idle", {31'd0, c_ready}, 32'd1);
        step();
        c_valid = 1'b0;
        chk("busy_after_acc", {28'd0, ch_busy}, 32'b0010);
        repeat (4) begin
            step();
            chk("busy_hold", {28'd0, ch_busy}, 32'b0010);
            chk("no_upd_pending", {28'd0, upd}, 32'd0);
        end

        // Second write while pending is refused
        c_addr = 4'd2;
        c_data = 16'd777;
        c_valid = 1'b1;
        #1;
        chk("rdy_pending", {31'd0, c_ready}, 32'd0);
        step();
        c_valid = 1'b0;
`ifdef CD_CONFIG_STATUS_EN
        chk("err_sticky", {28'd0, err_sticky}, 32'b0010);
`endif
        // Other channels stay writable
        c_addr = 4'd1;
        #1;
        chk("rdy_other", {31'd0, c_ready}, 32'd1);

        sb.push_back('{ch: 1, val: 16'd1302});
        ch_tick = 4'b0010;
        step();
        ch_tick = '0;
        expect_upd(4, n);
        chk("tick_latency", n, 32'd0);
        chk("lim0_keep", {16'd0, lim_of(0)}, 32'd2604);
        chk("lim2_keep", {16'd0, lim_of(2)}, 32'd2604);
        chk("lim3_keep", {16'd0, lim_of(3)}, 32'd2604);
        chk("busy_clear", {28'd0, ch_busy}, 32'd0);

        // Zero data on channel 2, no tick: forced commit of clamped value
        write(4'd3, 16'd0);
        sb.push_back('{ch: 2, val: 16'd1});
        expect_upd(1100, n);
        chk("timeout_latency", n, 32'd1024);
`ifdef CD_CONFIG_STATUS_EN
        chk("to_sticky", {28'd0, to_sticky}, 32'b0100);
`endif

        // Same value recommitted still pulses upd
        write(4'd2, 16'd1302);
        sb.push_back('{ch: 1, val: 16'd1302});
        ch_tick = 4'b0010;
        step();
        ch_tick = '0;
        expect_upd(4, n);

        // Accept and tick together on channel 0: tick ignored
        c_addr  = 4'd1;
        c_data  = 16'd500;
        c_valid = 1'b1;
        ch_tick = 4'b0001;
        step();
        c_valid = 1'b0;
        ch_tick = '0;
        chk("acc_tick_busy", {28'd0, ch_busy}, 32'b0001);
        chk("acc_tick_no_upd", {28'd0, upd}, 32'd0);
        chk("acc_tick_lim", {16'd0, lim_of(0)}, 32'd2604);
        step();
        step();
        chk("acc_tick_still_busy", {28'd0, ch_busy}, 32'b0001);
        sb.push_back('{ch: 0, val: 16'd500});
        ch_tick = 4'b0001;
        step();
        ch_tick = '0;
        expect_upd(4, n);

        // Unmapped addresses: handshake, no state change
        c_addr  = 4'd7;
        c_data  = 16'd9;
        c_valid = 1'b1;
        #1;
        chk("rdy_unmapped", {31'd0, c_ready}, 32'd1);
        step();
        c_valid = 1'b0;
`ifndef CD_CONFIG_STATUS_EN
        write(4'd0, 16'd9);
`else
        write(4'd0, 16'hF);
        chk("err_clr", {28'd0, err_sticky}, 32'd0);
        chk("to_clr", {28'd0, to_sticky}, 32'd0);
`endif
        chk("unmapped_busy", {28'd0, ch_busy}, 32'd0);
        chk("unmapped_lim0", {16'd0, lim_of(0)}, 32'd500);
        chk("unmapped_upd", {28'd0, upd}, 32'd0);

        // Reset while channel 3 is pending
        write(4'd4, 16'd100);
        chk("ch3_busy", {28'd0, ch_busy}, 32'b1000);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_lim3", {16'd0, lim_of(3)}, 32'd2604);
        chk("rst_mid_lim1", {16'd0, lim_of(1)}, 32'd2604);
        chk("rst_mid_busy", {28'd0, ch_busy}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        ch_tick = 4'hF;
        upd_or = '0;
        step();
        ch_tick = '0;
        for (int k = 0; k < 10; k++) begin
            upd_or = upd_or | upd;
            step();
        end
        chk("no_upd_after_rst", {28'd0, upd_or}, 32'd0);
        chk("lim3_after_rst", {16'd0, lim_of(3)}, 32'd2604);
        chk("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cd_config_mc.md
Name: cd_config_mc

Overview:
- Multi-channel clock-divider configuration block.
- Holds one divider limit per channel and accepts writes over a valid/ready config bus.
- Applies a new limit only at the addressed divider's period boundary (tick), so the output clock never glitches.
- Sits between the config bus decoder and a bank of NUM_CH clock-divider counters; each counter consumes lim[i] and restarts on upd[i].

Parameters:
NUM_CH, 4, number of divider channels (1..15)
WIDTH_CONFIG_ADDR, 4, config address width; must satisfy 2^WIDTH_CONFIG_ADDR > NUM_CH
WIDTH_LIMIT, 16, width of each divider limit value
RESET_LIMIT, {NUM_CH{16'd2604}}, packed per-channel reset limits; channel i is in bits [i*WIDTH_LIMIT +: WIDTH_LIMIT]
TIMEOUT, 1024, cycles a pending write waits for a tick before forced commit; 0 = wait forever
WIDTH_TO, 11, timeout counter width; must hold the value TIMEOUT

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
c_addr  in  WIDTH_CONFIG_ADDR  channel select; value k (1..NUM_CH) targets channel k-1; 0 and values above NUM_CH are unmapped
c_data  in  WIDTH_LIMIT  new divider limit
c_valid  in  1  write request
c_ready  out  1  addressed channel can accept; combinational from c_addr and channel state
ch_tick  in  NUM_CH  one-cycle period-end pulse from each divider
lim  out  NUM_CH*WIDTH_LIMIT  active limits, packed
upd  out  NUM_CH  one-cycle pulse when a channel's limit changes; divider clears its counter
ch_busy  out  NUM_CH  channel has an uncommitted write

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: lim = RESET_LIMIT, upd = 0, ch_busy = 0, all channels IDLE, all timeout counters 0.
- Reset mid-operation: any pending write is discarded and the limit returns to RESET_LIMIT.
- Per-channel FSM, state IDLE:
  - c_ready = 1 when this channel is addressed.
  - Accept occurs when c_valid & c_ready.
  - On accept: pend[i] <= (c_data == 0 ? 1 : c_data), i.e. zero is clamped to 1; go to PENDING.
- Per-channel FSM, state PENDING:
  - ch_busy[i] = 1; c_ready = 0 when this channel is addressed; writes to this channel are not accepted.
  - Commit when ch_tick[i] = 1, or when TIMEOUT != 0 and the timeout counter reaches TIMEOUT-1.
  - On commit: lim[i] <= pend[i]; upd[i] = 1 for exactly the next cycle; return to IDLE.
- Timeout counter:
  - Cleared on accept.
  - Increments each cycle in PENDING.
  - Saturates; never wraps.
- Latency: accept at edge N; tick sampled at edge M > N; lim updates at edge M; upd is high during cycle M..M+1.
- Simultaneous events:
  - Accept and tick in the same cycle on the same IDLE channel: the tick is ignored and the channel enters PENDING to wait for the next tick.
  - Ticks are never sampled in IDLE.
- Committing the same value as the current limit still pulses upd.
- Unmapped address: c_ready = 1, the write is accepted and dropped, no state changes.
- Channels are independent: a pending write on one channel never blocks another channel.
- Only one write per cycle (single bus).

Optional Feature:
- Macro: CD_CONFIG_STATUS_EN.
- When defined, two extra outputs:
  - err_sticky (NUM_CH): set when c_valid targets a busy channel; cleared by a write with c_addr = 0 and c_data[i] = 1.
  - to_sticky (NUM_CH): set on a forced timeout commit; cleared the same way.
  - Both reset to 0.
  - With the macro, address 0 is the clear command and is not a dropped write.
- When undefined: ports absent; address 0 behaves as unmapped.

Test Plan:
- Reset with default parameters: lim = 2604 on all four channels, ch_busy = 0, c_ready = 1 for every address, upd = 0.
- Write addr 2, data 1302, then pulse ch_tick[1] 5 cycles later:
  - ch_busy[1] = 1 until the tick.
  - lim[1] = 1302 at the tick edge; upd[1] pulses for exactly one cycle.
  - Other channels unchanged.
- Second write to addr 2 while pending: c_ready = 0 and pend keeps 1302. With CD_CONFIG_STATUS_EN, err_sticky[1] = 1.
- Write addr 3, data 0, with no ticks:
  - Forced commit after 1024 cycles; lim[2] = 1; upd[2] pulses.
  - With the macro, to_sticky[2] = 1.
- Write addr 1 with ch_tick[0] high in the same cycle:
  - No commit on that tick.
  - Commit on the next ch_tick[0].
- Assert rst_n low while channel 3 is pending: lim[3] = 2604, ch_busy = 0. No upd after release until a new write and tick.
